uart_tx_serializer: RTL

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_tx_serializer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//
// Byte-wide UART transmitter. A byte is accepted when tx_valid and tx_ready
// are both high on a rising clock edge. It is then sent as one frame:
// a start bit (0), eight data bits LSB first, an optional even-parity bit,
// and a stop bit (1). Every bit lasts CLOCKS_PER_BIT clocks.
//
// A byte offered during the last clock of a stop bit is accepted there.
// Its start bit then follows the stop bit with no idle cycles between.
//
// Build option:
//   PARITY_EN  When defined, an even-parity bit is sent after data bit 7,
//              which gives an 11-bit frame. When undefined, the frame has
//              10 bits and the parity state is absent.
//
// Parameters:
//   CLOCKS_PER_BIT  System clocks per UART bit. Must be at least 2.
//
// Ports:
//   clk         system clock; all state changes on its rising edge
//   reset       asynchronous, active-high reset
//   tx_data     byte to send; sampled only on an accepted transfer
//   tx_valid    tx_data is valid this cycle
//   tx_ready    a byte can be accepted this cycle
//   serial_out  registered UART line, high when idle
//   busy        high from the start bit through the stop bit
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int CLOCKS_PER_BIT = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       serial_out,
    output logic       busy
);

    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLOCKS_PER_BIT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]    state_reg, state_next;
    logic [CW-1:0] cnt_reg,   cnt_next;
    logic [2:0]    idx_reg,   idx_next;
    logic [7:0]    shift_reg, shift_next;
    logic          line_reg,  line_next;

    logic bit_done;
    logic transfer;

    assign bit_done   = (cnt_reg == CNT_MAX);
    // Ready in IDLE, and in the last clock of STOP so that back-to-back
    // bytes leave no gap on the line.
    assign tx_ready   = (state_reg == IDLE) || ((state_reg == STOP) && bit_done);
    assign transfer   = tx_valid && tx_ready;
    assign busy       = (state_reg != IDLE);
    assign serial_out = line_reg;

    // line_next is the level of the bit that the next state drives. This
    // keeps serial_out a plain flop with exactly one clock of latency.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        line_next  = line_reg;
        // The counter restarts at every bit boundary. It also stays cleared
        // in IDLE, so each new frame starts from zero.
        if ((state_reg == IDLE) || bit_done) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + CW'(1);
        end

        case (state_reg)
            IDLE: begin
                if (transfer) begin
                    state_next = START;
                    shift_next = tx_data;
                    line_next  = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_next = DATA;
                    idx_next   = 3'd0;
                    line_next  = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (idx_reg == 3'd7) begin
                        idx_next   = 3'd0;
`ifdef PARITY_EN
                        state_next = PARITY;
                        line_next  = ^shift_reg;
`else
                        state_next = STOP;
                        line_next  = 1'b1;
`endif
                    end else begin
                        idx_next  = idx_reg + 3'd1;
                        line_next = shift_reg[idx_reg + 3'd1];
                    end
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_next = STOP;
                    line_next  = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (transfer) begin
                        state_next = START;
                        shift_next = tx_data;
                        line_next  = 1'b0;
                    end else begin
                        state_next = IDLE;
                        line_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = 3'd0;
                line_next  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= 3'd0;
            shift_reg <= 8'd0;
            line_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
            line_reg  <= line_next;
        end
    end

endmodule
